// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared lamp encodings, state codes and counter sizing for tlc_param
// Purpose : types and helpers imported by every tlc_param file.
// Optional: TLC_PED_EN adds the PED_WALK state code.
package tlc_pkg;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  // The state value is the observable phase code, so the encoding is fixed.
  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
`ifdef TLC_PED_EN
    RED_BA   = 3'd5,
    PED_WALK = 3'd6
`else
    RED_BA   = 3'd5
`endif
  } state_t;

  function automatic int max_dur(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold every value 0..max duration.
  function automatic int cnt_width(int dur);
    return $clog2(dur + 1);
  endfunction

endpackage

// File: rtl/tlc_param_if.sv
// rtl/tlc_param_if.sv - sensor and lamp bundle between controller and intersection
// Purpose : groups sensors, lamp drivers and phase observation.
// Ports   : Ta/Tb sensors, La/Lb lamps, phase code; with TLC_PED_EN also ped_req/walk.
// Modports: master = controller, slave = intersection side.
interface tlc_param_if;
  logic       Ta;
  logic       Tb;
  logic [1:0] La;
  logic [1:0] Lb;
  logic [2:0] phase;
`ifdef TLC_PED_EN
  logic       ped_req;
  logic       walk;

  modport master (input Ta, Tb, ped_req, output La, Lb, phase, walk);
  modport slave  (output Ta, Tb, ped_req, input La, Lb, phase, walk);
`else
  modport master (input Ta, Tb, output La, Lb, phase);
  modport slave  (output Ta, Tb, input La, Lb, phase);
`endif
endinterface

// File: rtl/tlc_dwell_timer.sv
// rtl/tlc_dwell_timer.sv - saturating dwell counter with synchronous clear
// Purpose : counts cycles spent in the current phase.
// Ports   : clk, rst (async, active-high), clr (zero on next edge), cnt (count out).
module tlc_dwell_timer #(
  parameter int WIDTH = 4,
  parameter int SAT   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] SAT_V = WIDTH'(SAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != SAT_V) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tlc_param.sv
// rtl/tlc_param.sv - parametrised two-street traffic light controller
// Purpose : green/yellow/all-red sequencing with min/max green and Moore lamp decode.
// Ports   : clk, reset (async, active-high), bus (tlc_param_if.master: Ta, Tb, La, Lb, phase).
// Optional: TLC_PED_EN adds ped_req/walk and the PED_WALK phase after RED_BA.
module tlc_param
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN     = 4,
  parameter int MAX_GREEN     = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 3
) (
  input  logic         clk,
  input  logic         reset,
  tlc_param_if.master  bus
);

  localparam int MAX_DUR = max_dur(MAX_GREEN, YELLOW_CYCLES, ALLRED_CYCLES, WALK_CYCLES);
  localparam int CW      = cnt_width(MAX_DUR);

  // Last-cycle values of each phase; a phase ends on the edge that sees these.
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] RED_LAST = CW'(ALLRED_CYCLES - 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          state_change;

  // Saturating at the longest phase keeps the counter meaningful for every
  // phase; with ordinary settings that is MAX_GREEN-1.
  tlc_dwell_timer #(
    .WIDTH (CW),
    .SAT   (MAX_DUR - 1)
  ) u_timer (
    .clk (clk),
    .rst (reset),
    .clr (state_change),
    .cnt (cnt)
  );

  assign state_change = (next_state != state);

`ifdef TLC_PED_EN
  localparam logic [CW-1:0] WALK_LAST = CW'(WALK_CYCLES - 1);
  logic ped_pending;

  // Request captured at any time; consumed only when PED_WALK is entered.
  // A request on the entry edge itself is kept for the following round.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_pending <= 1'b0;
    end else if (bus.ped_req) begin
      ped_pending <= 1'b1;
    end else if (state == RED_BA && next_state == PED_WALK) begin
      ped_pending <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= A_GREEN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      A_GREEN:  if ((cnt >= MIN_LAST && !bus.Ta) || cnt == MAX_LAST) next_state = A_YELLOW;
      A_YELLOW: if (cnt == YEL_LAST) next_state = RED_AB;
      RED_AB:   if (cnt == RED_LAST) next_state = B_GREEN;
      B_GREEN:  if ((cnt >= MIN_LAST && !bus.Tb) || cnt == MAX_LAST) next_state = B_YELLOW;
      B_YELLOW: if (cnt == YEL_LAST) next_state = RED_BA;
`ifdef TLC_PED_EN
      RED_BA:   if (cnt == RED_LAST) next_state = ped_pending ? PED_WALK : A_GREEN;
      PED_WALK: if (cnt == WALK_LAST) next_state = A_GREEN;
`else
      RED_BA:   if (cnt == RED_LAST) next_state = A_GREEN;
`endif
      default:  next_state = A_GREEN;
    endcase
  end

  // Moore decode from the state register only; unlisted codes show all-red.
  always_comb begin
    bus.La    = LAMP_RED;
    bus.Lb    = LAMP_RED;
    bus.phase = state;
`ifdef TLC_PED_EN
    bus.walk  = (state == PED_WALK);
`endif
    case (state)
      A_GREEN:  bus.La = LAMP_GREEN;
      A_YELLOW: bus.La = LAMP_YELLOW;
      B_GREEN:  bus.Lb = LAMP_GREEN;
      B_YELLOW: bus.Lb = LAMP_YELLOW;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_tlc_param.sv
// tb/tb_tlc_param.sv - self-checking bench for tlc_param with a phase-duration reference model
module tb_tlc_param;

  localparam int MIN_GREEN     = 4;
  localparam int MAX_GREEN     = 8;
  localparam int YELLOW_CYCLES = 2;
  localparam int ALLRED_CYCLES = 1;
  localparam int WALK_CYCLES   = 3;

  logic clk;
  logic reset;
  tlc_param_if bus ();

  tlc_param #(
    .MIN_GREEN     (MIN_GREEN),
    .MAX_GREEN     (MAX_GREEN),
    .YELLOW_CYCLES (YELLOW_CYCLES),
    .ALLRED_CYCLES (ALLRED_CYCLES),
    .WALK_CYCLES   (WALK_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: phase number, cycles already spent in it, pending walk request.
  int m_phase;
  int m_age;
  bit m_ped;
  int hist [8];

  task automatic chk(string tag, int obs, int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_la(int ph);
    case (ph)
      0: return 0;
      1: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int exp_lb(int ph);
    case (ph)
      3: return 0;
      4: return 1;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_age = 0;
    m_ped = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int done;
    int nxt;
    bit req;
    done = m_age + 1;
    nxt = m_phase;
    req = 0;
`ifdef TLC_PED_EN
    req = bus.ped_req;
`endif
    case (m_phase)
      0: if ((done >= MIN_GREEN && !bus.Ta) || done >= MAX_GREEN) nxt = 1;
      1: if (done >= YELLOW_CYCLES) nxt = 2;
      2: if (done >= ALLRED_CYCLES) nxt = 3;
      3: if ((done >= MIN_GREEN && !bus.Tb) || done >= MAX_GREEN) nxt = 4;
      4: if (done >= YELLOW_CYCLES) nxt = 5;
      5: if (done >= ALLRED_CYCLES) nxt = m_ped ? 6 : 0;
      6: if (done >= WALK_CYCLES) nxt = 0;
      default: nxt = 0;
    endcase
    m_ped = req || (m_ped && !(m_phase == 5 && nxt == 6));
    m_age = (nxt != m_phase) ? 0 : done;
    m_phase = nxt;
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".phase"}, int'(bus.phase), m_phase);
    chk({tag, ".La"}, int'(bus.La), exp_la(m_phase));
    chk({tag, ".Lb"}, int'(bus.Lb), exp_lb(m_phase));
`ifdef TLC_PED_EN
    chk({tag, ".walk"}, int'(bus.walk), (m_phase == 6) ? 1 : 0);
`endif
  endtask

  task automatic cycle(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic run_count(int n, string tag);
    for (int i = 0; i < 8; i++) hist[i] = 0;
    repeat (n) begin
      cycle(tag);
      hist[bus.phase]++;
    end
  endtask

  // Reset released between edges so the next edge is an ordinary one.
  task automatic apply_reset(string tag);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #2;
    model_reset();
    check_outputs(tag);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_phase(int target, int budget, string tag);
    int n;
    n = 0;
    while (int'(bus.phase) != target && n < budget) begin
      cycle(tag);
      n++;
    end
    chk({tag, ".reached"}, int'(bus.phase), target);
  endtask

  initial begin
    reset = 1'b1;
    bus.Ta = 1'b0;
    bus.Tb = 1'b0;
`ifdef TLC_PED_EN
    bus.ped_req = 1'b0;
`endif
    model_reset();
    #12;
    check_outputs("reset");
    chk("reset.La", int'(bus.La), 0);
    chk("reset.Lb", int'(bus.Lb), 2);
    reset = 1'b0;

    // No traffic: 4/2/1 per street, period 14.
    run_count(14, "idle");
    chk("idle.a_green_len", hist[0], 4);
    chk("idle.a_yellow_len", hist[1], 2);
    chk("idle.red_ab_len", hist[2], 1);
    chk("idle.b_green_len", hist[3], 4);
    chk("idle.b_yellow_len", hist[4], 2);
    chk("idle.period", int'(bus.phase), 0);

    // Ta held: A green runs to MAX_GREEN, B still gets its minimum.
    apply_reset("rst2");
    bus.Ta = 1'b1;
    run_count(18, "ta_hold");
    chk("ta_hold.a_green_len", hist[0], 8);
    chk("ta_hold.b_green_len", hist[3], 4);

    // Ta high for 5 cycles, then low: yellow on the first edge sampling Ta=0.
    apply_reset("rst3");
    bus.Ta = 1'b1;
    repeat (5) cycle("ta5");
    chk("ta5.still_green", int'(bus.phase), 0);
    bus.Ta = 1'b0;
    cycle("ta5");
    chk("ta5.yellow", int'(bus.phase), 1);

    // Ta dropped before MIN_GREEN: still 4 green cycles.
    apply_reset("rst4");
    bus.Ta = 1'b1;
    cycle("ta_early");
    bus.Ta = 1'b0;
    repeat (2) cycle("ta_early");
    chk("ta_early.green3", int'(bus.phase), 0);
    cycle("ta_early");
    chk("ta_early.yellow", int'(bus.phase), 1);

    // Asynchronous reset in the middle of B_GREEN.
    bus.Tb = 1'b1;
    wait_phase(3, 40, "to_bgreen");
    cycle("in_bgreen");
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst.phase", int'(bus.phase), 0);
    chk("async_rst.La", int'(bus.La), 0);
    chk("async_rst.Lb", int'(bus.Lb), 2);
    model_reset();
    #2;
    reset = 1'b0;
    bus.Tb = 1'b0;

    // Both streets loaded: strict alternation at MAX_GREEN.
    bus.Ta = 1'b1;
    bus.Tb = 1'b1;
    run_count(44, "both");
    chk("both.a_served", int'(hist[0] >= 8), 1);
    chk("both.b_served", int'(hist[3] >= 8), 1);

`ifdef TLC_PED_EN
    apply_reset("rst_ped");
    bus.Ta = 1'b0;
    bus.Tb = 1'b0;
    wait_phase(3, 40, "ped_to_b");
    bus.ped_req = 1'b1;
    cycle("ped_pulse");
    bus.ped_req = 1'b0;
    run_count(20, "ped_round");
    chk("ped.walk_len", hist[6], 3);
    run_count(20, "ped_next");
    chk("ped.no_repeat", hist[6], 0);
`endif

    // Random sensor traffic held in short bursts.
    bus.Ta = 1'b0;
    bus.Tb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.Ta = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.Tb = 1'($urandom_range(0, 1));
`ifdef TLC_PED_EN
      bus.ped_req = ($urandom_range(0, 29) == 0);
`endif
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
